// File: rtl/elevator_call_panel.sv
// elevator_call_panel
//   Hall-side request initiator for the car controller. It debounces four
//   landing call buttons and latches them as pending calls that drive the
//   lamps. It issues one one-hot floor request at a time. Arrival is learned
//   by decoding the car's 7-segment floor display together with the door
//   status.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   btn[3:0]       raw asynchronous call buttons (bit0=G .. bit3=F3)
//   car_seg[6:0]   car floor display, active-low segments {g..a}
//   car_door_open  car door open status
//   overload       car overload flag (blocks new requests only)
//   firealarm      building fire alarm (recall to ground)
//   req_g..req_f3  registered one-hot floor request to the car
//   call_lamp[3:0] pending-call lamps, same bit order as btn
//   car_floor[1:0] last validly decoded car floor
//   timeout_pulse  one-cycle pulse when a request is withdrawn on timeout
//
// States
//   IDLE        | no request outstanding; picks the next target
//   WAIT_ARRIVE | request held until arrival, timeout or fire alarm
//   FIRE        | ground recall; calls suppressed until the car is at G
//                 with the alarm cleared

module elevator_call_panel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic [6:0] car_seg,
  input  logic       car_door_open,
  input  logic       overload,
  input  logic       firealarm,
  output logic       req_g,
  output logic       req_f1,
  output logic       req_f2,
  output logic       req_f3,
  output logic [3:0] call_lamp,
  output logic [1:0] car_floor,
  output logic       timeout_pulse
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ARRIVE = 2'd1,
    FIRE        = 2'd2
  } state_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  localparam logic [3:0] DEB_MAX  = 4'(DEBOUNCE_CYCLES);
  localparam logic [7:0] TIME_MAX = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  dir_t       dir;
  logic [3:0] req;
  logic [1:0] tgt_q;
  logic [7:0] timer;

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] deb_cnt [4];
  logic [3:0] deb_level;
  logic [3:0] deb_prev;
  logic [3:0] rise;

  logic       seg_valid;
  logic [1:0] seg_floor;
  logic [3:0] arrive;
  logic       clear_all;

  logic [1:0] up_tgt;
  logic       up_found;
  logic [1:0] dn_tgt;
  logic       dn_found;
  logic [1:0] tgt;
  dir_t       dir_sel;

  assign req_g  = req[0];
  assign req_f1 = req[1];
  assign req_f2 = req[2];
  assign req_f3 = req[3];

  // --------------------------------------------------------------------
  // Button synchronizer and debounce
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      deb_prev <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      deb_prev <= deb_level;
      for (int i = 0; i < 4; i++) begin
        if (!sync2[i]) deb_cnt[i] <= '0;
        else if (deb_cnt[i] != DEB_MAX) deb_cnt[i] <= deb_cnt[i] + 4'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) deb_level[i] = (deb_cnt[i] == DEB_MAX);
  end

  // deb_prev follows the level in every state, so a button held through
  // FIRE does not produce a late call when FIRE is left.
  assign rise = deb_level & ~deb_prev;

  // --------------------------------------------------------------------
  // Car floor decode
  // --------------------------------------------------------------------
  always_comb begin
    seg_valid = 1'b1;
    seg_floor = 2'd0;
    case (car_seg)
      7'b1000000: seg_floor = 2'd0;
      7'b1111001: seg_floor = 2'd1;
      7'b0100100: seg_floor = 2'd2;
      7'b0110000: seg_floor = 2'd3;
      default:    seg_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) car_floor <= 2'd0;
    else if (seg_valid) car_floor <= seg_floor;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) arrive[i] = car_door_open && (car_floor == 2'(i));
  end

  // --------------------------------------------------------------------
  // Pending calls. Arrival beats a same-cycle press. Lamps are also wiped on
  // the cycle the alarm sends the FSM into FIRE.
  // --------------------------------------------------------------------
  assign clear_all = firealarm || (state == FIRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) call_lamp <= '0;
    else if (clear_all) call_lamp <= '0;
    else call_lamp <= (call_lamp | rise) & ~arrive;
  end

  // --------------------------------------------------------------------
  // Target selection (only consumed when call_lamp != 0)
  // --------------------------------------------------------------------
  always_comb begin
    up_tgt   = 2'd0;
    up_found = 1'b0;
    dn_tgt   = 2'd0;
    dn_found = 1'b0;
    // Descending scan: the last hit is the lowest floor above the car.
    for (int i = 3; i >= 0; i--) begin
      if (call_lamp[i] && (i > int'(car_floor))) begin
        up_tgt   = 2'(i);
        up_found = 1'b1;
      end
    end
    // Ascending scan: the last hit is the highest floor below the car.
    for (int i = 0; i < 4; i++) begin
      if (call_lamp[i] && (i < int'(car_floor))) begin
        dn_tgt   = 2'(i);
        dn_found = 1'b1;
      end
    end
  end

  always_comb begin
    tgt     = car_floor;
    dir_sel = dir;
    if (call_lamp[car_floor]) begin
      tgt = car_floor;
    end else if (dir == DIR_UP) begin
      if (up_found) begin
        tgt = up_tgt;
      end else begin
        tgt     = dn_tgt;
        dir_sel = DIR_DOWN;
      end
    end else begin
      if (dn_found) begin
        tgt = dn_tgt;
      end else begin
        tgt     = up_tgt;
        dir_sel = DIR_UP;
      end
    end
  end

  // --------------------------------------------------------------------
  // Request FSM
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dir           <= DIR_UP;
      req           <= '0;
      tgt_q         <= 2'd0;
      timer         <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (firealarm) begin
            state <= FIRE;
            req   <= 4'b0001;
          end else if (!overload && (call_lamp != 4'b0000)) begin
            state <= WAIT_ARRIVE;
            req   <= 4'b0001 << tgt;
            tgt_q <= tgt;
            dir   <= dir_sel;
            timer <= '0;
          end
        end
        WAIT_ARRIVE: begin
          if (firealarm) begin
            state <= FIRE;
            req   <= 4'b0001;
          end else if (arrive[tgt_q]) begin
            state <= IDLE;
            req   <= '0;
          end else if (timer == TIME_MAX) begin
            // Lamp stays set, so IDLE reissues the same call.
            state         <= IDLE;
            req           <= '0;
            timeout_pulse <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        FIRE: begin
          req <= 4'b0001;
          if (!firealarm && arrive[0]) begin
            state <= IDLE;
            req   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          req   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_call_panel.sv
// Testbench for elevator_call_panel. Expected changes of the request bus
// and timeout pulse are queued by the stimulus and checked by a monitor as
// they appear. Lamps and floor decode are checked inline.

module tb_elevator_call_panel;

  localparam logic [6:0] SEG0   = 7'b1000000;
  localparam logic [6:0] SEG1   = 7'b1111001;
  localparam logic [6:0] SEG2   = 7'b0100100;
  localparam logic [6:0] SEG3   = 7'b0110000;
  localparam logic [6:0] SEGBLK = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic [6:0] car_seg;
  logic       car_door_open;
  logic       overload;
  logic       firealarm;
  logic       req_g, req_f1, req_f2, req_f3;
  logic [3:0] call_lamp;
  logic [1:0] car_floor;
  logic       timeout_pulse;

  logic [3:0] reqv;
  assign reqv = {req_f3, req_f2, req_f1, req_g};

  int errors = 0;
  int checks = 0;

  logic [4:0] exp_q [$];
  logic [4:0] prev_obs = 5'b0;

  elevator_call_panel #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn           (btn),
    .car_seg       (car_seg),
    .car_door_open (car_door_open),
    .overload      (overload),
    .firealarm     (firealarm),
    .req_g         (req_g),
    .req_f1        (req_f1),
    .req_f2        (req_f2),
    .req_f3        (req_f3),
    .call_lamp     (call_lamp),
    .car_floor     (car_floor),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  // Monitor: every change of {req, timeout_pulse} must match the next
  // queued expectation; the request bus must never be more than one-hot.
  always @(negedge clk) begin
    logic [4:0] cur;
    logic [4:0] e;
    cur = {reqv, timeout_pulse};
    checks++;
    if ($countones(reqv) > 1) begin
      errors++;
      $display("FAIL onehot: req=%b", reqv);
    end
    if (cur !== prev_obs) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event: got req=%b tp=%b, expected no change", cur[4:1], cur[0]);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL event: got req=%b tp=%b, expected req=%b tp=%b",
                   cur[4:1], cur[0], e[4:1], e[0]);
        end
      end
      prev_obs = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_ev(input logic [3:0] r, input logic tp);
    exp_q.push_back({r, tp});
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; btn = 4'b0; car_seg = SEGBLK;
    car_door_open = 1'b0; overload = 1'b0; firealarm = 1'b0;
    #1;
    chk("reset_req",   {4'b0, reqv}, 8'h00);
    chk("reset_lamp",  {4'b0, call_lamp}, 8'h00);
    chk("reset_floor", {6'b0, car_floor}, 8'h00);
    chk("reset_tp",    {7'b0, timeout_pulse}, 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // 1: short press rejected, long press accepted, arrival at F2
    btn = 4'b0100; tick(3); btn = 4'b0; tick(8);
    chk("short_press_lamp", {4'b0, call_lamp}, 8'h00);
    btn = 4'b0100; tick(6);
    chk("lamp_before_deb", {4'b0, call_lamp}, 8'h00);
    tick(1);
    chk("lamp_at_deb", {4'b0, call_lamp}, 8'h04);
    push_ev(4'b0100, 1'b0);
    tick(3);
    btn = 4'b0; car_seg = SEG2; car_door_open = 1'b1;
    push_ev(4'b0000, 1'b0);
    tick(2);
    chk("f2_arrive_lamp", {4'b0, call_lamp}, 8'h00);
    chk("f2_arrive_floor", {6'b0, car_floor}, 8'h02);

    // 2: car at F1 going up, calls at G and F3: F3 first, then G
    car_door_open = 1'b0; car_seg = SEG1; tick(1);
    chk("floor1", {6'b0, car_floor}, 8'h01);
    btn = 4'b1001; tick(7);
    chk("lamps_g_f3", {4'b0, call_lamp}, 8'h09);
    push_ev(4'b1000, 1'b0);
    btn = 4'b0; tick(1);
    car_seg = SEG3; car_door_open = 1'b1;
    push_ev(4'b0000, 1'b0);
    push_ev(4'b0001, 1'b0);
    tick(2);
    car_door_open = 1'b0; tick(1);
    chk("lamp_after_f3", {4'b0, call_lamp}, 8'h01);
    car_seg = SEG0; car_door_open = 1'b1;
    push_ev(4'b0000, 1'b0);
    tick(2);
    car_door_open = 1'b0;
    chk("lamp_after_g", {4'b0, call_lamp}, 8'h00);

    // 3: overload holds an active request and blocks a new one
    btn = 4'b0010; tick(7);
    chk("lamp_f1", {4'b0, call_lamp}, 8'h02);
    push_ev(4'b0010, 1'b0);
    btn = 4'b0; tick(1);
    overload = 1'b1; tick(5);
    chk("req_hold_overload", {4'b0, reqv}, 8'h02);
    car_seg = SEG1; car_door_open = 1'b1;
    push_ev(4'b0000, 1'b0);
    tick(2);
    car_door_open = 1'b0;
    btn = 4'b1000; tick(7);
    chk("lamp_f3_overload", {4'b0, call_lamp}, 8'h08);
    btn = 4'b0; tick(5);
    chk("no_req_overload", {4'b0, reqv}, 8'h00);
    overload = 1'b0;
    push_ev(4'b1000, 1'b0);
    tick(1);

    // 4: timeout after 15 cycles, lamp kept, request reissued
    tick(14);
    chk("req_before_timeout", {3'b0, reqv, timeout_pulse}, 8'h10);
    push_ev(4'b0000, 1'b1);
    push_ev(4'b1000, 1'b0);
    tick(1);
    chk("lamp_at_timeout", {4'b0, call_lamp}, 8'h08);
    chk("tp_at_timeout", {7'b0, timeout_pulse}, 8'h01);
    tick(1);
    chk("tp_after_timeout", {7'b0, timeout_pulse}, 8'h00);

    // 5: fire alarm during a request for F2
    car_seg = SEG3; car_door_open = 1'b1;
    push_ev(4'b0000, 1'b0);
    tick(2);
    car_door_open = 1'b0;
    btn = 4'b0100; tick(7);
    chk("lamp_f2_again", {4'b0, call_lamp}, 8'h04);
    push_ev(4'b0100, 1'b0);
    btn = 4'b0; tick(1);
    firealarm = 1'b1;
    push_ev(4'b0001, 1'b0);
    tick(1);
    chk("fire_lamp_clear", {4'b0, call_lamp}, 8'h00);
    btn = 4'b0010; tick(8);
    chk("fire_press_ignored", {4'b0, call_lamp}, 8'h00);
    btn = 4'b0;
    firealarm = 1'b0; tick(3);
    chk("fire_held", {4'b0, reqv}, 8'h01);
    car_seg = SEG0; car_door_open = 1'b1;
    push_ev(4'b0000, 1'b0);
    tick(2);
    car_door_open = 1'b0; tick(3);
    chk("after_fire_lamp", {4'b0, call_lamp}, 8'h00);

    // 6: invalid display codes, then asynchronous reset mid-request
    car_seg = SEG2; tick(1);
    chk("floor2", {6'b0, car_floor}, 8'h02);
    car_seg = SEGBLK; tick(3);
    chk("blank_keeps_floor", {6'b0, car_floor}, 8'h02);
    car_seg = 7'b0000000; tick(1);
    chk("invalid_keeps_floor", {6'b0, car_floor}, 8'h02);
    btn = 4'b1000; tick(7);
    chk("lamp_f3_pre_reset", {4'b0, call_lamp}, 8'h08);
    push_ev(4'b1000, 1'b0);
    btn = 4'b0; tick(1);
    chk("req_pre_reset", {4'b0, reqv}, 8'h08);
    push_ev(4'b0000, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("async_reset_req", {4'b0, reqv}, 8'h00);
    chk("async_reset_lamp", {4'b0, call_lamp}, 8'h00);
    tick(2);
    rst_n = 1'b1;
    chk("reset_floor_cleared", {6'b0, car_floor}, 8'h00);
    tick(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
Hall-side initiator for the car controller's request interface. It debounces four floor call buttons, latches pending calls and drives lamps. It issues exactly one one-hot floor request (req_g..req_f3) at a time and holds it until the car reports arrival, which it learns by decoding the car's 7-segment floor display and door status. Sits between the landing button panels and the car controller.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized-high cycles needed to accept a press (1..15)
TIMEOUT_CYCLES, 15, max cycles in WAIT_ARRIVE before the request is withdrawn (1..255)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn  input  4  raw asynchronous call buttons; bit0=G, bit1=F1, bit2=F2, bit3=F3
car_seg  input  7  car floor display, active-low segments {g..a}
car_door_open  input  1  car door open status
overload  input  1  car overload flag
firealarm  input  1  building fire alarm
req_g, req_f1, req_f2, req_f3  output  1 each  registered one-hot floor request to car
call_lamp  output  4  pending-call lamps, same bit order as btn
car_floor  output  2  last valid decoded car floor
timeout_pulse  output  1  one-cycle pulse when a request is withdrawn on timeout

Behaviour:
- Reset (rst_n low, async): req_* = 0, call_lamp = 0, car_floor = 0, timeout_pulse = 0, dir = up, state = IDLE, all synchronizer, debounce and timer registers = 0.
- Input path: each btn bit passes through a 2-flop synchronizer, then a per-bit debounce counter. The counter increments while the sync output is high and clears on low. Debounced level = 1 when the count reaches DEBOUNCE_CYCLES; the count saturates there.
- A rising edge of the debounced level sets call_lamp[f] on the next clock. A button held high from cycle 0 gives call_lamp[f] = 1 at cycle DEBOUNCE_CYCLES+3. A held button registers only once.
- Seg decode: 1000000→0, 1111001→1, 0100100→2, 0110000→3. Any other code, including blank 1111111, leaves car_floor unchanged. car_floor is registered, 1 cycle latency.
- arrive[f] = car_door_open & (car_floor == f).
- arrive[f] clears call_lamp[f]. If a set and a clear of the same bit occur in the same cycle, the clear wins (a press at a served floor is ignored).
- FSM states: IDLE, WAIT_ARRIVE, FIRE.
- IDLE: if firealarm → FIRE. Otherwise, if overload = 0 and call_lamp ≠ 0, select target t and go to WAIT_ARRIVE, asserting req_t on the next cycle.
- Target selection: if dir = up, take the lowest pending floor > car_floor; if none, take the highest pending floor < car_floor and set dir = down. Down is symmetric. A pending call at car_floor itself is selected first.
- WAIT_ARRIVE: req_t is held constant, including through overload.
  - arrive[t] → req_* = 0, return to IDLE.
  - firealarm → FIRE.
  - Timer reaches TIMEOUT_CYCLES → req_* = 0, timeout_pulse = 1 for one cycle, return to IDLE. call_lamp[t] stays set, so the call is retried.
  - The timer counts only in WAIT_ARRIVE and clears on entry.
- FIRE: req_g = 1 and all other req = 0. call_lamp is forced to 0 every cycle and button edges are ignored.
  - Exit to IDLE when firealarm = 0 and arrive[0] = 1.
  - firealarm dropping before ground arrival does not exit FIRE.
- Output invariant: at most one req_* is high in any cycle. All req_* change only on clk edges.
- Reset mid-request: all outputs drop asynchronously and pending calls are lost.

Test Plan:
1. DEBOUNCE_CYCLES=4. Press btn[2] for 3 cycles, release → call_lamp stays 0. Press for 10 cycles → call_lamp[2]=1 at cycle 7 and req_f2=1 one cycle after the IDLE decision. Then car_seg=0100100 with car_door_open=1 → req_f2=0 and call_lamp[2]=0 within 2 cycles.
2. Car at floor 1, dir up, calls pending at 0 and 3 → req_f3 issued first. After arrival at 3, req_g is issued and dir=down.
3. req_f1 active with overload=1 → req_f1 stays high. In IDLE with overload=1 and calls pending → no request issued until overload=0.
4. TIMEOUT_CYCLES=15, req_f3 active, no arrival → at cycle 15 req_f3=0, timeout_pulse=1 for 1 cycle, call_lamp[3] still 1, and req_f3 is reissued.
5. firealarm=1 during WAIT_ARRIVE for F2 → req_g=1, req_f2=0, call_lamp=0, presses ignored. Drop firealarm before ground arrival → FIRE held. Then seg=1000000 with door open → IDLE.
6. Invalid car_seg=1111111 while car_floor=2 → car_floor stays 2. Assert rst_n=0 mid-request → all req_* and call_lamp go to 0 immediately, without waiting for a clk edge.
